// File: rtl/motor_ramp_pkg.sv
// motor_ramp_pkg
//   Shared definitions for the motor command ramp stage.
//   - Default parameter values for duty resolution, ramp step, tick divider
//     and reversal dwell (PWM_RES must track the downstream PWM block).
//   - ramp_state_e: ramp FSM state encoding, also exported on the debug port.
package motor_ramp_pkg;

    localparam int PWM_RES       = 8;
    localparam int RAMP_STEP     = 16;
    localparam int RAMP_TICK_DIV = 4;
    localparam int RAMP_DWELL    = 2;

    typedef enum logic {
        ST_RAMP  = 1'b0,
        ST_DWELL = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/motor_ramp_counter.sv
// motor_ramp_counter
//   Generic wrap-around counter MIN..MAX in increments of STEP. Used as the
//   ramp tick divider: ovf_o pulses for the cycle in which the count sits at
//   MAX and is about to wrap.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset (count <- MIN)
//   en_i   count enable
//   clr_i  synchronous clear to MIN, priority over en_i
//   ovf_o  wrap event (combinational from the count register and en/clr)
module motor_ramp_counter #(
    parameter int WIDTH = 2,
    parameter int MIN   = 0,
    parameter int MAX   = 3,
    parameter int STEP  = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic ovf_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == WIDTH'(MAX));
    assign ovf_o  = en_i && !clr_i && at_max;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = WIDTH'(MIN);
        end else if (en_i) begin
            count_d = at_max ? WIDTH'(MIN) : count_q + WIDTH'(STEP);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= WIDTH'(MIN);
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/motor_ramp.sv
// motor_ramp
//   Command-shaping stage in front of the PWM generator. Accepts a signed
//   speed command, slews the unsigned duty word toward |cmd| by `step` once
//   per ramp tick, and inserts a zero-duty brake dwell before any direction
//   reversal.
// Handshake: a command transfers on every rising edge where
//   cmd_valid && cmd_ready; cmd_ready is registered, low in reset and high
//   from the first cycle after reset onward. The transfer only updates the
//   target; the ramp logic sees it from the next tick on.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         channel enable; low forces duty to 0 and clears the divider
//   cmd        signed speed command (nbits+1), negative = reverse
//   cmd_valid  command valid
//   cmd_ready  command can be accepted (registered)
//   duty       unsigned duty word to the PWM
//   dir        H-bridge direction, 0 = forward, 1 = reverse
//   brake      high while dwelling before a reversal
//   busy       duty/dir not yet at the latched target
//   dbg_state  current ramp FSM state
module motor_ramp
    import motor_ramp_pkg::*;
#(
    parameter int nbits    = PWM_RES,
    parameter int step     = RAMP_STEP,
    parameter int tick_div = RAMP_TICK_DIV,
    parameter int dwell    = RAMP_DWELL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [nbits:0]   cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [nbits-1:0] duty,
    output logic             dir,
    output logic             brake,
    output logic             busy,
    output ramp_state_e      dbg_state
);

    if (dwell < 1 || tick_div < 1 || step < 1 || step > (2 ** nbits) - 1) begin : g_bad_param
        $fatal(1, "motor_ramp: illegal parameters dwell=%0d tick_div=%0d step=%0d",
               dwell, tick_div, step);
    end

    localparam int DIVW = $clog2(tick_div + 1);
    localparam int DCW  = $clog2(dwell + 1);
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(dwell - 1);
    localparam logic [nbits:0] STEP_X    = (nbits + 1)'(step);

    ramp_state_e      state_q, state_d;
    logic [nbits-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic             brake_q, brake_d;
    logic             busy_q, busy_d;
    logic             ready_q;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic             tdir_q, tdir_d;
    logic [nbits-1:0] tmag_q, tmag_d;

    logic             tick;
    logic             accept;
    logic             same_dir;
    logic [nbits:0]   cmd_neg;
    logic [nbits-1:0] cmd_mag;
    logic [nbits:0]   duty_x, tmag_x, sum_up, diff_dn;
    logic [nbits-1:0] ramp_up, ramp_dn_tgt, ramp_dn_zero;

    motor_ramp_counter #(
        .WIDTH (DIVW),
        .MIN   (0),
        .MAX   (tick_div - 1),
        .STEP  (1)
    ) u_tick_div (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .clr_i (!en),
        .ovf_o (tick)
    );

    assign accept = cmd_valid && ready_q;

    // -2**nbits has no positive counterpart in nbits bits: saturate.
    assign cmd_neg = -cmd;
    assign cmd_mag = !cmd[nbits] ? cmd[nbits-1:0]
                   : (cmd_neg[nbits] ? '1 : cmd_neg[nbits-1:0]);

    // A zero target has no direction, so it is treated as same-direction
    // and simply ramps duty down without a reversal.
    assign same_dir = (tdir_q == dir_q) || (tmag_q == '0);

    // One extra bit so step over/underflow is visible before clamping.
    assign duty_x       = {1'b0, duty_q};
    assign tmag_x       = {1'b0, tmag_q};
    assign sum_up       = duty_x + STEP_X;
    assign diff_dn      = duty_x - STEP_X;
    assign ramp_up      = (sum_up > tmag_x) ? tmag_q : sum_up[nbits-1:0];
    assign ramp_dn_tgt  = (diff_dn[nbits] || (diff_dn < tmag_x)) ? tmag_q : diff_dn[nbits-1:0];
    assign ramp_dn_zero = diff_dn[nbits] ? '0 : diff_dn[nbits-1:0];

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        brake_d = brake_q;
        dcnt_d  = dcnt_q;
        tdir_d  = tdir_q;
        tmag_d  = tmag_q;

        if (accept) begin
            tdir_d = cmd[nbits];
            tmag_d = cmd_mag;
        end

        if (!en) begin
            duty_d  = '0;
            brake_d = 1'b0;
            state_d = ST_RAMP;
        end else if (tick) begin
            case (state_q)
                ST_RAMP: begin
                    if (same_dir) begin
                        if (duty_q < tmag_q) begin
                            duty_d = ramp_up;
                        end else if (duty_q > tmag_q) begin
                            duty_d = ramp_dn_tgt;
                        end
                    end else if (duty_q != '0) begin
                        duty_d = ramp_dn_zero;
                    end else begin
                        state_d = ST_DWELL;
                        dcnt_d  = '0;
                        brake_d = 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (!same_dir) begin
                        if (dcnt_q == DCNT_LAST) begin
                            // Direction flips on the last dwell tick, duty still 0.
                            dir_d   = tdir_q;
                            brake_d = 1'b0;
                            state_d = ST_RAMP;
                        end else begin
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end else begin
                        brake_d = 1'b0;
                        state_d = ST_RAMP;
                    end
                end
                default: state_d = ST_RAMP;
            endcase
        end

        // Computed from next-state values so busy changes on the same edge as duty.
        busy_d = (state_d == ST_DWELL) || (duty_d != tmag_d)
              || ((tmag_d != '0) && (dir_d != tdir_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RAMP;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            brake_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dcnt_q  <= '0;
            tdir_q  <= 1'b0;
            tmag_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            brake_q <= brake_d;
            busy_q  <= busy_d;
            ready_q <= 1'b1;
            dcnt_q  <= dcnt_d;
            tdir_q  <= tdir_d;
            tmag_q  <= tmag_d;
        end
    end

    assign cmd_ready = ready_q;
    assign duty      = duty_q;
    assign dir       = dir_q;
    assign brake     = brake_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp with nbits=8, step=16, tick_div=4, dwell=2.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// With en held high, the ramp tick lands on the 4th edge after reset release
// and every 4 edges after that; the sequence below keeps that alignment.
module tb_motor_ramp;
    import motor_ramp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [8:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  duty;
    logic        dir;
    logic        brake;
    logic        busy;
    ramp_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    motor_ramp #(
        .nbits    (8),
        .step     (16),
        .tick_div (4),
        .dwell    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .duty      (duty),
        .dir       (dir),
        .brake     (brake),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_wait();
        clk_n(4);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle transfer; cmd_ready is already high wherever this is used.
    task automatic send_cmd(input int v);
        cmd       = v[8:0];
        cmd_valid = 1'b1;
        clk_n(1);
        cmd_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        clk_n(2);
        rst = 1'b0;
        clk_n(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_duty"},  duty, 0);
        check({tag, "_dir"},   dir, 0);
        check({tag, "_brake"}, brake, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_ready"}, cmd_ready, 0);
        check({tag, "_state"}, dbg_state, ST_RAMP);
    endtask

    initial begin
        int up_seq[5]  = '{48, 64, 80, 96, 100};
        int dn_seq[6]  = '{68, 52, 36, 20, 4, 0};
        int rev_up[4]  = '{16, 32, 48, 50};

        rst = 1'b1; en = 1'b1; cmd = '0; cmd_valid = 1'b0;

        // Reset
        clk_n(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        clk_n(1);
        check("ready_after_reset", cmd_ready, 1);
        check("busy_after_reset", busy, 0);

        // Ramp up to +100
        send_cmd(100);
        check("busy_after_cmd", busy, 1);
        check("duty_before_tick", duty, 0);
        clk_n(2);
        check("up_16", duty, 16);
        clk_n(3);
        check("up_hold_between_ticks", duty, 16);
        clk_n(1);
        check("up_32", duty, 32);
        for (int i = 0; i < 5; i++) begin
            tick_wait();
            check($sformatf("up_%0d", up_seq[i]), duty, up_seq[i]);
            if (i == 3) check("busy_at_96", busy, 1);
        end
        check("busy_settled_100", busy, 0);

        // Reversal +100 -> -50
        send_cmd(-50);
        clk_n(3);
        check("rev_dn_84", duty, 84);
        for (int i = 0; i < 6; i++) begin
            tick_wait();
            check($sformatf("rev_dn_%0d", dn_seq[i]), duty, dn_seq[i]);
        end
        check("rev_dir_before_dwell", dir, 0);
        check("rev_brake_before_dwell", brake, 0);
        tick_wait();
        check("dwell1_brake", brake, 1);
        check("dwell1_dir", dir, 0);
        check("dwell1_state", dbg_state, ST_DWELL);
        check("dwell1_busy", busy, 1);
        tick_wait();
        check("dwell2_brake", brake, 1);
        check("dwell2_dir", dir, 0);
        tick_wait();
        check("flip_brake", brake, 0);
        check("flip_dir", dir, 1);
        check("flip_duty", duty, 0);
        for (int i = 0; i < 4; i++) begin
            tick_wait();
            check($sformatf("rev_up_%0d", rev_up[i]), duty, rev_up[i]);
        end
        check("rev_busy_settled", busy, 0);
        check("rev_dir_final", dir, 1);

        // Saturation: -256 from rest
        release_reset();
        send_cmd(-256);
        clk_n(2);
        check("sat_dwell_brake", brake, 1);
        check("sat_dwell_dir", dir, 0);
        tick_wait();
        tick_wait();
        check("sat_flip_dir", dir, 1);
        check("sat_flip_brake", brake, 0);
        repeat (15) tick_wait();
        check("sat_240", duty, 240);
        tick_wait();
        check("sat_255", duty, 255);
        tick_wait();
        check("sat_no_wrap", duty, 255);
        check("sat_busy", busy, 0);

        // Enable drop at duty 64, command accepted while disabled
        release_reset();
        send_cmd(100);
        clk_n(2);
        check("en_16", duty, 16);
        repeat (3) tick_wait();
        check("en_64", duty, 64);
        en = 1'b0;
        clk_n(1);
        check("en_low_duty", duty, 0);
        check("en_low_brake", brake, 0);
        check("en_low_dir", dir, 0);
        send_cmd(40);
        clk_n(2);
        check("en_low_hold", duty, 0);
        en = 1'b1;
        clk_n(3);
        check("en_restart_wait", duty, 0);
        clk_n(1);
        check("en_restart_16", duty, 16);
        tick_wait();
        check("en_restart_32", duty, 32);
        tick_wait();
        check("en_new_target_40", duty, 40);

        // Reset while dwelling on a reversal
        send_cmd(-100);
        clk_n(3);
        check("rst_dn_24", duty, 24);
        tick_wait();
        tick_wait();
        check("rst_dn_0", duty, 0);
        tick_wait();
        check("rst_pre_brake", brake, 1);
        rst = 1'b1;
        clk_n(1);
        check_reset_outputs("rst_mid");

        // Cancelled reversal during dwell
        rst = 1'b0;
        clk_n(1);
        send_cmd(100);
        clk_n(2);
        repeat (6) tick_wait();
        check("cancel_up_100", duty, 100);
        send_cmd(-50);
        clk_n(3);
        repeat (6) tick_wait();
        check("cancel_dn_0", duty, 0);
        tick_wait();
        check("cancel_in_dwell", brake, 1);
        send_cmd(30);
        clk_n(3);
        check("cancel_brake", brake, 0);
        check("cancel_dir", dir, 0);
        check("cancel_duty", duty, 0);
        check("cancel_state", dbg_state, ST_RAMP);
        tick_wait();
        check("cancel_16", duty, 16);
        tick_wait();
        check("cancel_30", duty, 30);
        check("cancel_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motor_ramp.md
# motor_ramp

Command-shaping stage directly upstream of the PWM generator in each motor channel. Accepts a signed speed command over a valid/ready handshake and slews the unsigned duty word toward the commanded magnitude at a fixed rate. Enforces a zero-duty brake dwell before every direction reversal. Drives the PWM duty input plus the H-bridge direction and brake lines.

## Interface
- `nbits`, default `` `PWM_RES ``: duty width; must equal the downstream PWM resolution.
- `step`, default `` `RAMP_STEP ``: duty increment/decrement per ramp tick, 1..2**nbits-1.
- `tick_div`, default `` `RAMP_TICK_DIV ``: clock cycles per ramp tick, ≥1.
- `dwell`, default `` `RAMP_DWELL ``: ramp ticks spent braking at zero before a reversal, ≥1.
- `clk` input 1: system clock (48 MHz).
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: channel enable; low forces duty to 0.
- `cmd` input nbits+1: signed two's-complement speed command. Negative means reverse.
- `cmd_valid` input 1: `cmd` is valid.
- `cmd_ready` output 1: command can be accepted.
- `duty` output nbits: unsigned duty word to the PWM `in` port.
- `dir` output 1: 0 = forward, 1 = reverse.
- `brake` output 1: high only while dwelling.
- `busy` output 1: high while `duty`/`dir` differ from the latched target.

## Operation
- **Reset values:** `duty` = 0, `dir` = 0, `brake` = 0, `cmd_ready` = 0, `busy` = 0, target = +0, state = RAMP, tick divider = 0.
- **Command handshake:**
  - `cmd_ready` is registered. It is 1 from the first cycle after `rst` deasserts and stays 1 thereafter.
  - A transfer occurs when `cmd_valid && cmd_ready`. It overwrites the target register (`tdir` = sign, `tmag` = |cmd|) on that edge.
  - `cmd` = -2**nbits saturates `tmag` to 2**nbits-1.
  - `tmag` = 0 keeps the current `dir`.
- **Tick:** a divider counts 0..tick_div-1 while `en`=1. The ramp update happens on the edge where the divider equals tick_div-1.
- **State RAMP** (on each tick):
  - If `tdir`==`dir`:
    - duty < tmag: duty ← min(duty+step, tmag).
    - duty > tmag: duty ← max(duty-step, tmag).
    - duty == tmag: no change.
  - If `tdir`≠`dir` and tmag>0:
    - duty > 0: duty ← max(duty-step, 0).
    - duty == 0: enter DWELL, dwell counter ← 0, `brake` ← 1.
- **State DWELL** (duty held at 0):
  - On each tick with `tdir`≠`dir` and tmag>0:
    - dwell counter < dwell-1: increment the counter.
    - dwell counter == dwell-1: `dir` ← `tdir`, `brake` ← 0, go to RAMP. Duty stays 0 on this tick.
  - On a tick with `tdir`==`dir` or tmag==0 (reversal cancelled): `brake` ← 0, go to RAMP, `dir` unchanged.
- **Enable low:** on the next edge, duty ← 0, `brake` ← 0, state ← RAMP, divider ← 0. `dir` and the target are retained, and commands are still accepted. When `en` returns high, ramping resumes from 0.
- **Arithmetic:** all sums and differences are computed in nbits+1 bits before clamping; `duty` never wraps.
- **busy** = (state==DWELL) || duty≠tmag || (tmag>0 && dir≠tdir). It is registered alongside `duty`.
- **rst mid-operation:** on the next edge, all outputs take their reset values regardless of state.
- **Parameter check:** `dwell`<1, `tick_div`<1, or `step`==0 must print an error at elaboration and call `$finish(1)`.

## Timing
- Command accepted at edge N. The first duty change occurs at the next tick edge, at most tick_div cycles later.
- Settling time for a same-direction move: ceil(|Δ|/step) ticks.
- Reversal from magnitude m:
  - ceil(m/step) ticks down to 0;
  - +1 tick to enter DWELL;
  - `dwell` ticks braking, with `dir` flipping on the last of these;
  - ramp-up begins on the following tick.
- `duty`, `dir`, `brake` and `busy` are all registered with zero combinational path from inputs, and change on the same edge.
- A command arriving on the same edge as a tick is not used by that tick; it takes effect from the next tick.

## Structure
- `src/config.vh` gains `` `RAMP_STEP ``, `` `RAMP_TICK_DIV `` and `` `RAMP_DWELL ``; `` `PWM_RES `` is shared with the PWM block.
- State encoding (RAMP, DWELL) is a pair of localparams inside the module.
- The tick divider instantiates the existing `counter` module (min 0, max tick_div-1, step 1). Its overflow is the tick and its `clr` is driven by `!en`.
- No other sub-modules.

## Test plan
Bench parameters: nbits=8, step=16, tick_div=4, dwell=2.
1. **Reset:** hold `rst` 3 cycles. Expect duty=0, dir=0, brake=0, busy=0, and cmd_ready=0 during reset, then 1 on the first cycle after release.
2. **Ramp up:** `cmd`=+100 with en=1. Expect duty 16,32,48,64,80,96,100 on consecutive ticks, 4 cycles apart. `busy` falls on the edge duty reaches 100.
3. **Reversal:** from +100 settled, `cmd`=-50. Expect:
   - duty 84,68,52,36,20,4,0;
   - then brake=1 for 2 ticks, with dir→1 and brake→0 on the second;
   - then duty 16,32,48,50.
4. **Saturation:** `cmd`=-256 from rest. Expect dir=1 after dwell and duty climbing to 255, with no wrap past 255.
5. **Enable drop:** deassert `en` mid-ramp at duty=64. Expect duty=0 next edge and brake=0; after re-enable, duty restarts at 16. Repeat with `rst` mid-ramp and expect all reset values next edge.
6. **Cancelled reversal:** during DWELL of a +100→-50 reversal, send `cmd`=+30. Expect brake=0 at the next tick, dir stays 0, and duty ramps 16,30.
